// File: rtl/verificador_bitmap.sv
// Walks the set bits of a head-entry bitmap and probes cluster memory for each one.
// A hash match or a memory timeout flags the entry as suspect.
module verificador_bitmap #(
  parameter  int NUM_CLUSTERS  = 8,
  parameter  int TAM_ENDERECO  = 2,
  parameter  int TAM_HASH_DOIS = 8,
  parameter  int TIMEOUT       = 15,
  localparam int IDX           = $clog2(NUM_CLUSTERS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        saida_valida,
  input  logic [NUM_CLUSTERS-1:0]     bitmap_atual,
  input  logic [TAM_ENDERECO-1:0]     endereco_atual,
  input  logic [TAM_HASH_DOIS-1:0]    hash_atual,
  output logic [NUM_CLUSTERS-1:0]     bitmap_atualizado,
  output logic                        zero,
  output logic                        suspeito,
  output logic                        mem_req,
  output logic [IDX+TAM_ENDERECO-1:0] mem_endereco,
  input  logic                        mem_valido,
  input  logic [TAM_HASH_DOIS-1:0]    mem_hash,
  output logic [15:0]                 contagem_suspeitos
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    OCIOSO,
    BUSCA,
    DECIDE
  } estado_t;

  estado_t                  r_state, w_state_n;
  logic [IDX-1:0]           r_idx, w_idx_n;
  logic [CW-1:0]            r_cnt, w_cnt_n;
  logic                     r_tmo, w_tmo_n;
  logic [TAM_HASH_DOIS-1:0] r_hash, w_hash_n;
  logic [15:0]              r_cont;

  logic [IDX-1:0]          w_low;
  logic [CW-1:0]           w_cnt_inc;
  logic [NUM_CLUSTERS-1:0] w_clr;
  logic                    w_req, w_zero, w_susp;
  logic [NUM_CLUSTERS-1:0] w_bmp;

  // Descending scan so the lowest set bit wins
  always_comb begin
    w_low = '0;
    for (int i = NUM_CLUSTERS - 1; i >= 0; i--) begin
      if (bitmap_atual[i]) w_low = IDX'(i);
    end
  end

  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_clr     = bitmap_atual & ~(NUM_CLUSTERS'(1) << r_idx);

  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_cnt_n   = r_cnt;
    w_tmo_n   = r_tmo;
    w_hash_n  = r_hash;
    w_req     = 1'b0;
    w_zero    = 1'b0;
    w_susp    = 1'b0;
    w_bmp     = bitmap_atual;
    if (!reset) begin
      unique case (r_state)
        OCIOSO: begin
          if (saida_valida) begin
            if (bitmap_atual == '0) begin
              w_zero = 1'b1;
            end else begin
              w_idx_n   = w_low;
              w_cnt_n   = '0;
              w_state_n = BUSCA;
            end
          end
        end
        BUSCA: begin
          w_req = 1'b1;
          if (mem_valido) begin
            w_hash_n  = mem_hash;
            w_tmo_n   = 1'b0;
            w_state_n = DECIDE;
          end else begin
            w_cnt_n = w_cnt_inc;
            if (w_cnt_inc == TMO) begin
              w_tmo_n   = 1'b1;
              w_state_n = DECIDE;
            end
          end
        end
        DECIDE: begin
          w_state_n = OCIOSO;
          if (r_tmo || (r_hash == hash_atual)) begin
            w_susp = 1'b1;
          end else begin
            w_bmp  = w_clr;
            w_zero = (w_clr == '0);
          end
        end
        default: w_state_n = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= OCIOSO;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_tmo   <= 1'b0;
      r_hash  <= '0;
      r_cont  <= '0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      r_cnt   <= w_cnt_n;
      r_tmo   <= w_tmo_n;
      r_hash  <= w_hash_n;
      if (w_susp && (r_cont != 16'hFFFF)) r_cont <= r_cont + 16'd1;
    end
  end

  assign bitmap_atualizado  = w_bmp;
  assign zero               = w_zero;
  assign suspeito           = w_susp;
  assign mem_req            = w_req;
  assign mem_endereco       = {r_idx, endereco_atual};
  assign contagem_suspeitos = r_cont;

endmodule

// File: tb/tb_verificador_bitmap.sv
// Directed bench for verificador_bitmap.
// Inputs change 1ns after the rising edge, outputs are checked 1ns later.
module tb_verificador_bitmap;

  logic        clk = 1'b0;
  logic        reset;
  logic        saida_valida;
  logic [7:0]  bitmap_atual;
  logic [1:0]  endereco_atual;
  logic [7:0]  hash_atual;
  logic [7:0]  bitmap_atualizado;
  logic        zero;
  logic        suspeito;
  logic        mem_req;
  logic [4:0]  mem_endereco;
  logic        mem_valido;
  logic [7:0]  mem_hash;
  logic [15:0] contagem_suspeitos;

  int n_cmp = 0;
  int n_bad = 0;

  verificador_bitmap dut (
    .clk               (clk),
    .reset             (reset),
    .saida_valida      (saida_valida),
    .bitmap_atual      (bitmap_atual),
    .endereco_atual    (endereco_atual),
    .hash_atual        (hash_atual),
    .bitmap_atualizado (bitmap_atualizado),
    .zero              (zero),
    .suspeito          (suspeito),
    .mem_req           (mem_req),
    .mem_endereco      (mem_endereco),
    .mem_valido        (mem_valido),
    .mem_hash          (mem_hash),
    .contagem_suspeitos(contagem_suspeitos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    saida_valida   = 1'b1;
    bitmap_atual   = 8'hFF;
    endereco_atual = 2'b11;
    hash_atual     = 8'hA5;
    mem_valido     = 1'b0;
    mem_hash       = 8'h00;
    step();
    step();
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_susp", 32'(suspeito), 32'd0);
    chk("rst_bmp", 32'(bitmap_atualizado), 32'hFF);
    chk("rst_cont", 32'(contagem_suspeitos), 32'd0);

    // empty bitmap in OCIOSO
    reset = 1'b0;
    bitmap_atual = 8'h00;
    #1;
    chk("empty_zero", 32'(zero), 32'd1);
    chk("empty_req", 32'(mem_req), 32'd0);
    step();
    saida_valida = 1'b0;
    #1;
    chk("empty_zero_off", 32'(zero), 32'd0);
    chk("empty_req_off", 32'(mem_req), 32'd0);

    // two-bit walk with mismatching hash
    saida_valida = 1'b1;
    bitmap_atual = 8'b0010_0100;
    #1;
    chk("w_idle_zero", 32'(zero), 32'd0);
    chk("w_idle_bmp", 32'(bitmap_atualizado), 32'h24);
    step();
    chk("w1_req", 32'(mem_req), 32'd1);
    chk("w1_addr", 32'(mem_endereco), 32'b010_11);
    mem_valido = 1'b1;
    mem_hash   = 8'h3C;
    step();
    mem_valido = 1'b0;
    #1;
    chk("w1_dec_req", 32'(mem_req), 32'd0);
    chk("w1_dec_susp", 32'(suspeito), 32'd0);
    chk("w1_dec_zero", 32'(zero), 32'd0);
    chk("w1_dec_bmp", 32'(bitmap_atualizado), 32'b0010_0000);
    bitmap_atual = 8'b0010_0000;
    step();
    chk("w2_idle_req", 32'(mem_req), 32'd0);
    step();
    chk("w2_addr", 32'(mem_endereco), 32'b101_11);
    mem_valido = 1'b1;
    step();
    mem_valido = 1'b0;
    #1;
    chk("w2_dec_zero", 32'(zero), 32'd1);
    chk("w2_dec_bmp", 32'(bitmap_atualizado), 32'h00);
    saida_valida = 1'b0;
    step();

    // top bit only, mismatch exhausts entry
    saida_valida = 1'b1;
    bitmap_atual = 8'b1000_0000;
    step();
    chk("top_addr", 32'(mem_endereco), 32'b111_11);
    mem_valido = 1'b1;
    mem_hash   = 8'h3C;
    step();
    mem_valido = 1'b0;
    #1;
    chk("top_zero", 32'(zero), 32'd1);
    chk("top_bmp", 32'(bitmap_atualizado), 32'h00);
    chk("top_susp", 32'(suspeito), 32'd0);
    saida_valida = 1'b0;
    step();
    chk("top_cont", 32'(contagem_suspeitos), 32'd0);

    // hash match
    saida_valida = 1'b1;
    bitmap_atual = 8'b0000_0001;
    step();
    chk("hit_addr", 32'(mem_endereco), 32'b000_11);
    mem_valido = 1'b1;
    mem_hash   = 8'hA5;
    step();
    mem_valido = 1'b0;
    #1;
    chk("hit_susp", 32'(suspeito), 32'd1);
    chk("hit_zero", 32'(zero), 32'd0);
    chk("hit_bmp", 32'(bitmap_atualizado), 32'h01);
    chk("hit_cont0", 32'(contagem_suspeitos), 32'd0);
    saida_valida = 1'b0;
    step();
    chk("hit_susp_off", 32'(suspeito), 32'd0);
    chk("hit_cont1", 32'(contagem_suspeitos), 32'd1);

    // timeout after 15 wait cycles
    saida_valida = 1'b1;
    bitmap_atual = 8'h10;
    mem_hash     = 8'h00;
    step();
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("tmo_wait%0d", i), 32'(mem_req), 32'd1);
      step();
    end
    chk("tmo_dec_req", 32'(mem_req), 32'd0);
    chk("tmo_susp", 32'(suspeito), 32'd1);
    chk("tmo_zero", 32'(zero), 32'd0);
    saida_valida = 1'b0;
    mem_valido   = 1'b1;
    mem_hash     = 8'hA5;
    step();
    chk("late_req", 32'(mem_req), 32'd0);
    chk("late_susp", 32'(suspeito), 32'd0);
    chk("late_cont", 32'(contagem_suspeitos), 32'd2);
    step();
    chk("late_susp2", 32'(suspeito), 32'd0);
    chk("late_cont2", 32'(contagem_suspeitos), 32'd2);
    mem_valido = 1'b0;

    // reset in the middle of BUSCA
    saida_valida = 1'b1;
    bitmap_atual = 8'h04;
    step();
    chk("mid_req", 32'(mem_req), 32'd1);
    step();
    reset = 1'b1;
    #1;
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    step();
    reset        = 1'b0;
    saida_valida = 1'b0;
    mem_valido   = 1'b1;
    #1;
    chk("post_req", 32'(mem_req), 32'd0);
    chk("post_cont", 32'(contagem_suspeitos), 32'd0);
    step();
    chk("post_late_susp", 32'(suspeito), 32'd0);
    mem_valido   = 1'b0;
    saida_valida = 1'b1;
    bitmap_atual = 8'h00;
    #1;
    chk("post_idle_zero", 32'(zero), 32'd1);
    chk("post_idle_req", 32'(mem_req), 32'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
